uart_register_port: RTL and testbench
=====================================

# uart_register_port

Serial-port peripheral that answers the core's hardware-register bus: the responder side of register_index/register_read/register_write. It decodes two register indices, returns read data one cycle after the access, queues transmit bytes in a small FIFO feeding an 8N1 serializer, and optionally captures received bytes. Several such responders share the bus; each drives zero on register_read_value when not selected, so the top level ORs them.

## Interface
- BASE_INDEX, 7'h00: register index of DATA; STATUS is BASE_INDEX+1 (must be even).
- CLKS_PER_BIT, 434: clock cycles per serial bit (≥4).
- TX_FIFO_DEPTH, 4: transmit FIFO entries, power of two, ≥2.
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- register_index  in  7  register selected by the core this cycle.
- register_read  in  1  read strobe.
- register_write  in  1  write strobe.
- register_write_value  in  16  write data.
- register_read_value  out  16  registered read data.
- uart_tx  out  1  serial output, idle high.
- uart_rx  in  1  serial input, asynchronous.

## Operation
- Write DATA: pushes register_write_value[7:0] into TX FIFO; if FIFO full, byte dropped, sticky tx_overflow set.
- Write STATUS: bits written 1 clear sticky flags (bit2 rx_overrun, bit4 rx_frame_err, bit5 tx_overflow); other bits ignored.
- Read DATA: returns {8'h0, rx_byte}; clears rx_valid (pop) at the same edge.
- Read STATUS: bit0 tx_full, bit1 rx_valid, bit2 rx_overrun, bit3 tx_busy (FIFO non-empty or shifter active), bit4 rx_frame_err, bit5 tx_overflow, others 0.
- Read/write to any other index: no effect.
- TX shifter: idle→START→DATA(8 bits, LSB first)→STOP→idle; each bit CLKS_PER_BIT cycles; pops FIFO when idle and non-empty.
- RX: 2-flop synchronizer; falling edge in idle → wait CLKS_PER_BIT/2, recheck low (else false start, back to idle); sample 8 data bits and stop bit at bit centres.
- Stop bit low: byte discarded, rx_frame_err set.
- Good byte while rx_valid already set: new byte discarded, old kept, rx_overrun set.
- DATA read pop and new byte completion in same cycle: new byte loaded, rx_valid stays 1, no overrun.

## Timing
- Reset: register_read_value=0, uart_tx=1, FIFO empty, rx_valid=0, all sticky flags 0, both FSMs idle.
- Read latency one cycle: register_read_value at edge N+1 reflects state sampled at edge N when register_read and index match; otherwise loads 0 every cycle.
- Write takes effect at the edge where register_write is high.
- FIFO push while full and shifter pop in the same cycle: push accepted, count unchanged.
- Byte written to empty FIFO with idle shifter: uart_tx falls 2 cycles after the write edge (push edge, pop/load edge).
- Back-to-back frames: next start bit begins the cycle after previous stop bit's last cycle.
- STATUS write clearing a flag in the same cycle it is set: set wins.
- reset_n assertion mid-frame aborts both directions immediately; uart_tx returns high.

## Configuration
- UART_RX_EN defined: receiver, rx_valid, rx_overrun, rx_frame_err implemented.
- Undefined: no receive logic; uart_rx ignored; DATA reads return 0; status bits 1, 2, 4 read 0; STATUS write clears only tx_overflow.

## Structure
- Package uart_register_pkg: register offsets (DATA=0, STATUS=1), status bit positions, TX/RX state enum.
- One sub-module: uart_tx_fifo (parameterized depth, push/pop/full/empty, simultaneous push+pop when full).
- Receiver and shifter FSMs in the top module.

## Test plan (CLKS_PER_BIT=4, BASE_INDEX=7'h10)
- Write 16'h00A5 to index 0x10 → uart_tx: start low 4 cycles, bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4; STATUS bit3 reads 0 afterward.
- Five writes 0x01..0x05 back-to-back with depth 4 → first byte popped to shifter, remaining four queued, all five transmitted in order, tx_overflow stays 0; sixth write while full → dropped, STATUS reads 16'h0029 (tx_full, busy, overflow).
- Drive 0x3C on uart_rx → STATUS 16'h0002, DATA read returns 16'h003C one cycle after strobe, next STATUS 16'h0000.
- Two frames 0x11, 0x22 with no read → DATA returns 0x11, rx_overrun=1; write 16'h0004 to STATUS → bit2 clears.
- Frame with stop bit low → rx_valid 0, rx_frame_err 1; 2-cycle low glitch on uart_rx → no effect.
- Read index 0x12 → register_read_value 0 next cycle; reset_n low mid-transmit → uart_tx high, STATUS 0 after release.

Source files
------------

// File: rtl/uart_register_pkg.sv
// Shared definitions for uart_register_port: register offsets, STATUS bit map
// and the serial FSM state encoding used by both the shifter and the receiver.
package uart_register_pkg;

  localparam logic [6:0] DATA_OFFSET   = 7'd0;
  localparam logic [6:0] STATUS_OFFSET = 7'd1;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_RX_VALID     = 1;
  localparam int ST_RX_OVERRUN   = 2;
  localparam int ST_TX_BUSY      = 3;
  localparam int ST_RX_FRAME_ERR = 4;
  localparam int ST_TX_OVERFLOW  = 5;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  function automatic logic [15:0] pack_status(
    input logic tx_full,
    input logic rx_valid,
    input logic rx_overrun,
    input logic tx_busy,
    input logic rx_frame_err,
    input logic tx_overflow
  );
    logic [15:0] s;
    s                  = 16'h0000;
    s[ST_TX_FULL]      = tx_full;
    s[ST_RX_VALID]     = rx_valid;
    s[ST_RX_OVERRUN]   = rx_overrun;
    s[ST_TX_BUSY]      = tx_busy;
    s[ST_RX_FRAME_ERR] = rx_frame_err;
    s[ST_TX_OVERFLOW]  = tx_overflow;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small power-of-two transmit FIFO. A push while full is still accepted when
// a pop happens in the same cycle, so the occupancy simply stays unchanged.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (count_r == {(AW+1){1'b0}});
  assign full      = (count_r == CNT_MAX);
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_register_port.sv
// Register-bus UART responder: DATA/STATUS registers, TX FIFO + 8N1 shifter,
// and an optional receiver enabled by defining UART_RX_EN.
module uart_register_port
  import uart_register_pkg::*;
#(
  parameter logic [6:0] BASE_INDEX    = 7'h00,
  parameter int         CLKS_PER_BIT  = 434,
  parameter int         TX_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic sel_data_s, sel_status_s;
  logic data_wr_s, status_wr_s, data_rd_s, status_rd_s;

  assign sel_data_s   = (register_index == (BASE_INDEX + DATA_OFFSET));
  assign sel_status_s = (register_index == (BASE_INDEX + STATUS_OFFSET));
  assign data_wr_s    = register_write && sel_data_s;
  assign status_wr_s  = register_write && sel_status_s;
  assign data_rd_s    = register_read && sel_data_s;
  assign status_rd_s  = register_read && sel_status_s;

  logic        wdata_unused_s;
  assign wdata_unused_s = ^register_write_value[15:8];

  // ---------------- transmit path ----------------
  logic        fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic [7:0]  fifo_data_s;
  uart_state_e tx_state_r, tx_state_s;
  logic [CW-1:0] tx_cnt_r, tx_cnt_s;
  logic [2:0]  tx_bit_r, tx_bit_s;
  logic [7:0]  tx_shift_r, tx_shift_s;
  logic        uart_tx_r, uart_tx_s;
  logic        tx_overflow_r;
  logic        tx_busy_s;

  uart_tx_fifo #(.DEPTH(TX_FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (data_wr_s),
    .push_data (register_write_value[7:0]),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign tx_busy_s = !fifo_empty_s || (tx_state_r != UART_IDLE);

  // Shifter next state; the stop cell's last cycle chains straight into the next start.
  always_comb begin
    tx_state_s = tx_state_r;
    tx_cnt_s   = tx_cnt_r;
    tx_bit_s   = tx_bit_r;
    tx_shift_s = tx_shift_r;
    fifo_pop_s = 1'b0;
    case (tx_state_r)
      UART_IDLE: begin
        tx_cnt_s = CNT_ZERO;
        tx_bit_s = 3'd0;
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          tx_shift_s = fifo_data_s;
          tx_state_s = UART_START;
        end else begin
          tx_state_s = UART_IDLE;
        end
      end
      UART_START: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s   = CNT_ZERO;
          tx_bit_s   = 3'd0;
          tx_state_s = UART_DATA;
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_ONE;
        end
      end
      UART_DATA: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s = CNT_ZERO;
          if (tx_bit_r == 3'd7) begin
            tx_state_s = UART_STOP;
          end else begin
            tx_bit_s = tx_bit_r + 3'd1;
          end
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_ONE;
        end
      end
      UART_STOP: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s = CNT_ZERO;
          tx_bit_s = 3'd0;
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            tx_shift_s = fifo_data_s;
            tx_state_s = UART_START;
          end else begin
            tx_state_s = UART_IDLE;
          end
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_ONE;
        end
      end
      default: begin
        tx_state_s = UART_IDLE;
        tx_cnt_s   = CNT_ZERO;
        tx_bit_s   = 3'd0;
      end
    endcase
  end

  // Line level follows the next state so uart_tx stays a clean flop output.
  always_comb begin
    uart_tx_s = 1'b1;
    case (tx_state_s)
      UART_START: uart_tx_s = 1'b0;
      UART_DATA:  uart_tx_s = tx_shift_s[tx_bit_s];
      UART_STOP:  uart_tx_s = 1'b1;
      default:    uart_tx_s = 1'b1;
    endcase
  end

  // Shifter state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_r <= UART_IDLE;
      tx_cnt_r   <= CNT_ZERO;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      uart_tx_r  <= 1'b1;
    end else begin
      tx_state_r <= tx_state_s;
      tx_cnt_r   <= tx_cnt_s;
      tx_bit_r   <= tx_bit_s;
      tx_shift_r <= tx_shift_s;
      uart_tx_r  <= uart_tx_s;
    end
  end

  // Sticky overflow: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_overflow_r <= 1'b0;
    end else begin
      tx_overflow_r <= (data_wr_s && fifo_full_s && !fifo_pop_s) ||
                       (tx_overflow_r && !(status_wr_s && register_write_value[ST_TX_OVERFLOW]));
    end
  end

  assign uart_tx = uart_tx_r;

  // ---------------- receive path ----------------
  logic       rx_valid_s, rx_overrun_s, rx_frame_err_s;
  logic [7:0] rx_byte_s;

`ifdef UART_RX_EN
  logic        rx_meta_r, rx_sync_r, rx_prev_r;
  uart_state_e rx_state_r, rx_state_s;
  logic [CW-1:0] rx_cnt_r, rx_cnt_s;
  logic [2:0]  rx_bit_r, rx_bit_s;
  logic [7:0]  rx_shift_r, rx_shift_s;
  logic        rx_good_s, rx_bad_s;
  logic        rx_valid_r, rx_overrun_r, rx_frame_err_r;
  logic [7:0]  rx_byte_r;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receiver next state: half-bit start recheck, then sample at bit centres.
  always_comb begin
    rx_state_s = rx_state_r;
    rx_cnt_s   = rx_cnt_r;
    rx_bit_s   = rx_bit_r;
    rx_shift_s = rx_shift_r;
    rx_good_s  = 1'b0;
    rx_bad_s   = 1'b0;
    case (rx_state_r)
      UART_IDLE: begin
        rx_cnt_s = CNT_ZERO;
        rx_bit_s = 3'd0;
        if (rx_prev_r && !rx_sync_r) begin
          rx_state_s = UART_START;
        end else begin
          rx_state_s = UART_IDLE;
        end
      end
      UART_START: begin
        if (rx_cnt_r == HALF_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_bit_s   = 3'd0;
          rx_state_s = rx_sync_r ? UART_IDLE : UART_DATA;
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      UART_DATA: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
          if (rx_bit_r == 3'd7) begin
            rx_state_s = UART_STOP;
          end else begin
            rx_bit_s = rx_bit_r + 3'd1;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      UART_STOP: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_state_s = UART_IDLE;
          rx_good_s  = rx_sync_r;
          rx_bad_s   = !rx_sync_r;
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      default: begin
        rx_state_s = UART_IDLE;
        rx_cnt_s   = CNT_ZERO;
        rx_bit_s   = 3'd0;
      end
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_r <= UART_IDLE;
      rx_cnt_r   <= CNT_ZERO;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
    end else begin
      rx_state_r <= rx_state_s;
      rx_cnt_r   <= rx_cnt_s;
      rx_bit_r   <= rx_bit_s;
      rx_shift_r <= rx_shift_s;
    end
  end

  // Holding register and sticky flags; a DATA pop frees the slot for a byte landing that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_byte_r      <= 8'h00;
      rx_valid_r     <= 1'b0;
      rx_overrun_r   <= 1'b0;
      rx_frame_err_r <= 1'b0;
    end else begin
      if (rx_good_s && (!rx_valid_r || data_rd_s)) begin
        rx_byte_r  <= rx_shift_r;
        rx_valid_r <= 1'b1;
      end else if (data_rd_s) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
      rx_overrun_r   <= (rx_good_s && rx_valid_r && !data_rd_s) ||
                        (rx_overrun_r && !(status_wr_s && register_write_value[ST_RX_OVERRUN]));
      rx_frame_err_r <= rx_bad_s ||
                        (rx_frame_err_r && !(status_wr_s && register_write_value[ST_RX_FRAME_ERR]));
    end
  end

  assign rx_valid_s     = rx_valid_r;
  assign rx_overrun_s   = rx_overrun_r;
  assign rx_frame_err_s = rx_frame_err_r;
  assign rx_byte_s      = rx_byte_r;
`else
  logic rx_unused_s;
  assign rx_unused_s    = uart_rx;
  assign rx_valid_s     = 1'b0;
  assign rx_overrun_s   = 1'b0;
  assign rx_frame_err_s = 1'b0;
  assign rx_byte_s      = 8'h00;
`endif

  // ---------------- read data ----------------
  logic [15:0] read_value_s, read_value_r;

  // Read mux; unselected cycles drive zero so responders can be ORed.
  always_comb begin
    read_value_s = 16'h0000;
    if (data_rd_s) begin
      read_value_s = {8'h00, rx_byte_s};
    end else if (status_rd_s) begin
      read_value_s = pack_status(fifo_full_s, rx_valid_s, rx_overrun_s,
                                 tx_busy_s, rx_frame_err_s, tx_overflow_r);
    end else begin
      read_value_s = 16'h0000;
    end
  end

  // Registered read data, one cycle after the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_value_r <= 16'h0000;
    end else begin
      read_value_r <= read_value_s;
    end
  end

  assign register_read_value = read_value_r;

endmodule

// File: tb/tb_uart_register_port.sv
// Scoreboard bench for uart_register_port (CLKS_PER_BIT=4, BASE_INDEX=7'h10);
// read and serial-frame monitors pop expectations queued by the stimulus.
module tb_uart_register_port;

  localparam logic [6:0] BASE   = 7'h10;
  localparam logic [6:0] STAT   = 7'h11;
  localparam int         CPB    = 4;

  logic        clk;
  logic        reset_n;
  logic [6:0]  register_index;
  logic        register_read;
  logic        register_write;
  logic [15:0] register_write_value;
  logic [15:0] register_read_value;
  logic        uart_tx;
  logic        uart_rx;

  uart_register_port #(.BASE_INDEX(BASE), .CLKS_PER_BIT(CPB), .TX_FIFO_DEPTH(4)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .register_index       (register_index),
    .register_read        (register_read),
    .register_write       (register_write),
    .register_write_value (register_write_value),
    .register_read_value  (register_read_value),
    .uart_tx              (uart_tx),
    .uart_rx              (uart_rx)
  );

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [15:0] rd_exp_q [$];
  string       rd_nm_q  [$];
  logic [7:0]  tx_exp_q [$];
  int          lat_q    [$];
  logic        rd_pend;
  logic        tx_mon_en  = 1'b1;
  logic        tx_in_frame = 1'b0;
  logic        gap_chk    = 1'b0;
  int          last_start = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_pend <= register_read && reset_n;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic rd, input logic wr, input logic [6:0] idx, input logic [15:0] wv);
    @(negedge clk);
    register_read        = rd;
    register_write       = wr;
    register_index       = idx;
    register_write_value = wv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 7'h00, 16'h0000);
  endtask

  task automatic wr(input logic [6:0] idx, input logic [15:0] v);
    bus(1'b0, 1'b1, idx, v);
  endtask

  task automatic rd(input logic [6:0] idx, input logic [15:0] exp, input string nm);
    bus(1'b1, 1'b0, idx, 16'h0000);
    rd_exp_q.push_back(exp);
    rd_nm_q.push_back(nm);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  task automatic wait_tx_idle(input string nm);
    int n;
    n = 0;
    while ((tx_exp_q.size() != 0 || tx_in_frame) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(nm, {31'd0, (tx_exp_q.size() == 0 && !tx_in_frame)}, 32'd1);
    idle(4);
  endtask

  // Read monitor: one cycle after each strobe, compare against the queued value.
  initial begin : rd_mon
    logic [15:0] e;
    string nm;
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        if (rd_exp_q.size() == 0) begin
          check("rd_unexpected", 32'd1, 32'd0);
        end else begin
          e  = rd_exp_q.pop_front();
          nm = rd_nm_q.pop_front();
          check(nm, {16'd0, register_read_value}, {16'd0, e});
        end
      end
    end
  end

  // Serial monitor: find the start bit, sample every cell centre, compare with queue.
  initial begin : tx_mon
    logic [7:0] b;
    logic [7:0] e;
    int st;
    int l;
    forever begin
      @(negedge clk);
      if (tx_mon_en && reset_n && uart_tx == 1'b0) begin
        tx_in_frame = 1'b1;
        st = cyc;
        if (lat_q.size() > 0) begin
          l = lat_q.pop_front();
          check("tx_start_latency", st, l);
        end
        if (gap_chk && last_start >= 0) check("tx_b2b_gap", st - last_start, 4 * 10 * CPB / 4);
        last_start = st;
        repeat (CPB / 2) @(negedge clk);
        check("tx_start_bit", {31'd0, uart_tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        check("tx_stop_bit", {31'd0, uart_tx}, 32'd1);
        if (tx_exp_q.size() == 0) begin
          check("tx_unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
        end else begin
          e = tx_exp_q.pop_front();
          check("tx_byte", {24'd0, b}, {24'd0, e});
        end
        tx_in_frame = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset_n              = 1'b0;
    register_read        = 1'b0;
    register_write       = 1'b0;
    register_index       = 7'h00;
    register_write_value = 16'h0000;
    uart_rx              = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("reset_read_value", {16'd0, register_read_value}, 32'd0);
    reset_n = 1'b1;
    idle(2);
    rd(STAT, 16'h0000, "reset_status");
    rd(BASE, 16'h0000, "reset_data");
    idle(2);

    // single byte A5: latency and bit order
    tx_exp_q.push_back(8'hA5);
    wr(BASE, 16'h00A5);
    lat_q.push_back(cyc + 2);
    idle(1);
    wait_tx_idle("tx_a5_done");
    rd(STAT, 16'h0000, "status_after_a5");
    idle(2);

    // burst of five, then a sixth write while full
    last_start = -1;
    gap_chk    = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tx_exp_q.push_back(8'(i));
      wr(BASE, 16'h7F00 | 16'(i));
    end
    rd(STAT, 16'h0009, "status_full_no_ovf");
    wr(BASE, 16'h0006);
    rd(STAT, 16'h0029, "status_full_ovf");
    idle(1);
    wait_tx_idle("tx_burst_done");
    gap_chk = 1'b0;
    rd(STAT, 16'h0020, "status_ovf_sticky");
    wr(STAT, 16'h0020);
    rd(STAT, 16'h0000, "status_ovf_cleared");
    idle(2);

`ifdef UART_RX_EN
    send_rx(8'h3C, 1'b1);
    idle(4);
    rd(STAT, 16'h0002, "rx_status_valid");
    rd(BASE, 16'h003C, "rx_data_3c");
    rd(STAT, 16'h0000, "rx_status_popped");
    idle(2);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    idle(4);
    rd(STAT, 16'h0006, "rx_status_overrun");
    rd(BASE, 16'h0011, "rx_data_kept_old");
    rd(STAT, 16'h0004, "rx_overrun_sticky");
    wr(STAT, 16'h0004);
    rd(STAT, 16'h0000, "rx_overrun_cleared");
    idle(2);
    send_rx(8'h55, 1'b0);
    idle(4);
    rd(STAT, 16'h0010, "rx_frame_err");
    wr(STAT, 16'h0010);
    rd(STAT, 16'h0000, "rx_frame_err_cleared");
    idle(1);
    uart_rx = 1'b0;
    idle(2);
    uart_rx = 1'b1;
    idle(50);
    rd(STAT, 16'h0000, "rx_glitch_ignored");
    idle(2);
`else
    send_rx(8'h3C, 1'b1);
    idle(4);
    rd(STAT, 16'h0000, "norx_status");
    rd(BASE, 16'h0000, "norx_data");
    wr(STAT, 16'h0014);
    rd(STAT, 16'h0000, "norx_status_after_clear");
    idle(2);
`endif

    // other index: read 0, write has no effect
    rd(7'h12, 16'h0000, "other_index_read");
    wr(7'h12, 16'h00FF);
    rd(STAT, 16'h0000, "other_index_no_effect");
    idle(60);

    // reset mid-frame
    tx_mon_en = 1'b0;
    wr(BASE, 16'h005A);
    idle(15);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midframe_reset_tx_high", {31'd0, uart_tx}, 32'd1);
    check("midframe_reset_read_zero", {16'd0, register_read_value}, 32'd0);
    idle(3);
    reset_n = 1'b1;
    idle(2);
    tx_mon_en = 1'b1;
    rd(STAT, 16'h0000, "status_after_reset");
    idle(60);
    check("tx_idle_after_reset", {31'd0, uart_tx}, 32'd1);
    check("rd_queue_drained", rd_exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
